// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared funct codes, MUX select constants and sequencer state encoding
`timescale 1ns/1ps
package alu_pkg;

  // Funct codes shared by the sequencer, the ALU/shifter and the result MUX
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

  // MUX select that drives dataOut to zero; also the idle value of alu_funct
  localparam logic [5:0] MUX_ZERO = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_DIV_INIT = 3'd2,
    ST_DIV_RUN  = 3'd3,
    ST_DIV_WB   = 3'd4
  } state_t;

  function automatic logic funct_is_legal(input logic [5:0] f);
    case (f)
      FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT,
      FUNCT_SLL, FUNCT_SRL, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // SRL shares the shifter bus with SLL; DIVU results go through Hi/Lo, so the MUX outputs zero
  function automatic logic [5:0] funct_to_mux(input logic [5:0] f);
    if (f == FUNCT_SRL) return FUNCT_SLL;
    if (f == FUNCT_DIVU || !funct_is_legal(f)) return MUX_ZERO;
    return f;
  endfunction

endpackage

// File: rtl/alu_step_counter.sv
// rtl/alu_step_counter.sv - up-counter with synchronous clear and terminal-count flag
`timescale 1ns/1ps
module alu_step_counter #(
  parameter int WIDTH    = 6,
  parameter int TERMINAL = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over enable so the counter never runs past the terminal value
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU front-end sequencer: accept funct, run single-cycle ops or the DIVU sequence
`timescale 1ns/1ps
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [5:0] in_funct,
  output logic       in_ready,
  output logic [5:0] alu_funct,
  output logic       div_init,
  output logic       div_step,
  output logic       hilo_we,
  output logic [5:0] mux_signal,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  state_t     state_q, state_d;
  logic [5:0] alu_funct_q, alu_funct_d;
  logic [5:0] mux_q, mux_d;
  logic       div_init_q, div_init_d;
  logic       div_step_q, div_step_d;
  logic       hilo_we_q, hilo_we_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_tc;

  alu_step_counter #(
    .WIDTH    (CW),
    .TERMINAL (DIV_CYCLES - 1)
  ) u_step_counter (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  // Next state and next registered outputs; every output pulse is computed one cycle ahead
  always_comb begin
    state_d     = state_q;
    alu_funct_d = alu_funct_q;
    mux_d       = mux_q;
    div_init_d  = 1'b0;
    div_step_d  = 1'b0;
    hilo_we_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_clr     = 1'b1;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          alu_funct_d = in_funct;
          if (in_funct == FUNCT_DIVU) begin
            state_d    = ST_DIV_INIT;
            div_init_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
            done_d  = 1'b1;
            err_d   = !funct_is_legal(in_funct);
            mux_d   = funct_to_mux(in_funct);
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
      end
      ST_DIV_INIT: begin
        state_d    = ST_DIV_RUN;
        div_step_d = 1'b1;
      end
      ST_DIV_RUN: begin
        if (cnt_tc) begin
          state_d   = ST_DIV_WB;
          hilo_we_d = 1'b1;
          done_d    = 1'b1;
          mux_d     = funct_to_mux(alu_funct_q);
        end else begin
          cnt_clr    = 1'b0;
          cnt_en     = 1'b1;
          div_step_d = 1'b1;
        end
      end
      ST_DIV_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, all returned to idle values immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alu_funct_q <= MUX_ZERO;
      mux_q       <= MUX_ZERO;
      div_init_q  <= 1'b0;
      div_step_q  <= 1'b0;
      hilo_we_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_funct_q <= alu_funct_d;
      mux_q       <= mux_d;
      div_init_q  <= div_init_d;
      div_step_q  <= div_step_d;
      hilo_we_q   <= hilo_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign alu_funct  = alu_funct_q;
  assign mux_signal = mux_q;
  assign div_init   = div_init_q;
  assign div_step   = div_step_q;
  assign hilo_we    = hilo_we_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer at DIV_CYCLES 32, 1 and 255
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid   [3];
  logic [5:0] in_funct   [3];
  logic       in_ready   [3];
  logic [5:0] alu_funct  [3];
  logic       div_init   [3];
  logic       div_step   [3];
  logic       hilo_we    [3];
  logic [5:0] mux_signal [3];
  logic       done       [3];
  logic       err        [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_op_sequencer #(
      .DIV_CYCLES (g == 0 ? 32 : (g == 1 ? 1 : 255))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[g]),
      .in_funct   (in_funct[g]),
      .in_ready   (in_ready[g]),
      .alu_funct  (alu_funct[g]),
      .div_init   (div_init[g]),
      .div_step   (div_step[g]),
      .hilo_we    (hilo_we[g]),
      .mux_signal (mux_signal[g]),
      .done       (done[g]),
      .err        (err[g])
    );
  end

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;

  logic [5:0] legal_tab [10] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                                 6'b000000, 6'b000010, 6'b011011, 6'b010000, 6'b010010};

  function automatic int ncyc(input int g);
    return (g == 0) ? 32 : ((g == 1) ? 1 : 255);
  endfunction

  function automatic bit m_legal(input logic [5:0] f);
    for (int i = 0; i < 10; i++) if (legal_tab[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] m_mux(input logic [5:0] f);
    if (f == F_SRL) return 6'b000000;
    if (f == F_DIVU || !m_legal(f)) return 6'b111111;
    return f;
  endfunction

  task automatic test_reset(input int g);
    checks++; if (in_ready[g] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b exp 1", g, in_ready[g]); end
    checks++; if (alu_funct[g] !== 6'b111111) begin errors++; $display("FAIL reset_alu_funct[%0d] got %b exp 111111", g, alu_funct[g]); end
    checks++; if (mux_signal[g] !== 6'b111111) begin errors++; $display("FAIL reset_mux[%0d] got %b exp 111111", g, mux_signal[g]); end
    checks++;
    if ({div_init[g], div_step[g], hilo_we[g], done[g], err[g]} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses[%0d] got %b exp 00000", g,
                         {div_init[g], div_step[g], hilo_we[g], done[g], err[g]});
    end
  endtask

  // One request on instance g; every timing event is checked against the cycle-offset model
  task automatic run_op(input int g, input logic [5:0] f);
    int n = ncyc(g);
    bit is_div = (f == F_DIVU);
    int exp_done = is_div ? n + 2 : 1;
    int done_k = 0, init_k = 0, init_cnt = 0, step_first = 0, step_last = 0, step_cnt = 0;
    int hilo_k = 0, hilo_cnt = 0;
    logic [5:0] mux_at_done = 'x, alu_at1 = 'x;
    logic err_at_done = 'x, ready_at1 = 'x;
    @(negedge clk);
    in_valid[g] = 1'b1; in_funct[g] = f;
    @(posedge clk);
    #1 in_valid[g] = 1'b0; in_funct[g] = 6'($urandom);
    for (int k = 1; k <= n + 8; k++) begin
      @(negedge clk);
      if (k == 1) begin ready_at1 = in_ready[g]; alu_at1 = alu_funct[g]; end
      if (div_init[g]) begin init_cnt++; init_k = k; end
      if (div_step[g]) begin step_cnt++; if (step_first == 0) step_first = k; step_last = k; end
      if (hilo_we[g])  begin hilo_cnt++; hilo_k = k; end
      if (done[g]) begin done_k = k; mux_at_done = mux_signal[g]; err_at_done = err[g]; break; end
    end
    checks++; if (ready_at1 !== 1'b0) begin errors++; $display("FAIL busy_ready g%0d f%b got %b exp 0", g, f, ready_at1); end
    checks++; if (alu_at1 !== f) begin errors++; $display("FAIL alu_funct g%0d got %b exp %b", g, alu_at1, f); end
    checks++; if (done_k != exp_done) begin errors++; $display("FAIL done_cycle g%0d f%b got %0d exp %0d", g, f, done_k, exp_done); end
    checks++; if (mux_at_done !== m_mux(f)) begin errors++; $display("FAIL mux g%0d f%b got %b exp %b", g, f, mux_at_done, m_mux(f)); end
    checks++; if (err_at_done !== !m_legal(f)) begin errors++; $display("FAIL err g%0d f%b got %b exp %b", g, f, err_at_done, !m_legal(f)); end
    checks++; if (init_cnt != (is_div ? 1 : 0) || init_k != (is_div ? 1 : 0)) begin
      errors++; $display("FAIL div_init g%0d got cnt %0d at %0d exp %0d", g, init_cnt, init_k, is_div ? 1 : 0); end
    checks++; if (step_cnt != (is_div ? n : 0) || step_first != (is_div ? 2 : 0) || step_last != (is_div ? n + 1 : 0)) begin
      errors++; $display("FAIL div_step g%0d got cnt %0d span %0d..%0d exp cnt %0d", g, step_cnt, step_first, step_last, is_div ? n : 0); end
    checks++; if (hilo_cnt != (is_div ? 1 : 0) || hilo_k != (is_div ? n + 2 : 0)) begin
      errors++; $display("FAIL hilo_we g%0d got cnt %0d at %0d exp at %0d", g, hilo_cnt, hilo_k, is_div ? n + 2 : 0); end
    @(negedge clk);
    checks++; if (in_ready[g] !== 1'b1 || done[g] !== 1'b0) begin
      errors++; $display("FAIL after_done g%0d got ready %b done %b exp 1 0", g, in_ready[g], done[g]); end
    checks++; if (mux_signal[g] !== m_mux(f)) begin errors++; $display("FAIL mux_hold g%0d got %b exp %b", g, mux_signal[g], m_mux(f)); end
  endtask

  // DIVU followed by MFHI with in_valid held high the whole time
  task automatic test_back_to_back(input int g);
    int n = ncyc(g);
    int first_ready = 0, acc_div_done = 0, mfhi_done = 0;
    logic [5:0] mfhi_mux = 'x;
    bit accepted2 = 1'b0;
    @(negedge clk);
    in_valid[g] = 1'b1; in_funct[g] = F_DIVU;
    @(posedge clk);
    #1 in_funct[g] = F_MFHI;
    for (int k = 1; k <= n + 8; k++) begin
      @(negedge clk);
      if (done[g] && acc_div_done == 0) acc_div_done = k;
      else if (done[g]) begin mfhi_done = k; mfhi_mux = mux_signal[g]; end
      if (in_ready[g] && !accepted2) begin
        first_ready = k; accepted2 = 1'b1;
        @(posedge clk);
        #1 in_valid[g] = 1'b0;
      end
    end
    in_valid[g] = 1'b0;
    checks++; if (acc_div_done != n + 2) begin errors++; $display("FAIL b2b_div_done got %0d exp %0d", acc_div_done, n + 2); end
    checks++; if (first_ready != n + 3) begin errors++; $display("FAIL b2b_accept got %0d exp %0d", first_ready, n + 3); end
    checks++; if (mfhi_done != n + 4) begin errors++; $display("FAIL b2b_mfhi_done got %0d exp %0d", mfhi_done, n + 4); end
    checks++; if (mfhi_mux !== F_MFHI) begin errors++; $display("FAIL b2b_mfhi_mux got %b exp %b", mfhi_mux, F_MFHI); end
  endtask

  task automatic test_reset_mid_op();
    int bad = 0;
    @(negedge clk);
    in_valid[0] = 1'b1; in_funct[0] = F_DIVU;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++; if (div_step[0] !== 1'b1) begin errors++; $display("FAIL mid_op_running got %b exp 1", div_step[0]); end
    reset = 1'b1;
    #1;
    test_reset(0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hilo_we[0] || done[0] || div_step[0] || !in_ready[0]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL post_reset_quiet got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_random(input int iters);
    for (int i = 0; i < iters; i++) begin
      int g = int'($urandom_range(0, 2));
      logic [5:0] f;
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = legal_tab[$urandom_range(0, 9)];
      if (g == 2 && f == F_DIVU && $urandom_range(0, 1) == 0) g = 1;
      run_op(g, f);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin in_valid[g] = 1'b0; in_funct[g] = 6'd0; end
    #12;
    for (int g = 0; g < 3; g++) test_reset(g);
    @(negedge clk);
    reset = 1'b0;
    run_op(0, F_ADD);
    run_op(0, F_SRL);
    run_op(0, 6'b111000);
    run_op(0, F_DIVU);
    run_op(1, F_DIVU);
    run_op(2, F_DIVU);
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_op();
    run_op(0, F_DIVU);
    test_random(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
